// File: rtl/cmult_arbiter.sv
// cmult_arbiter: round-robin sharing of one pipelined complex multiplier between two
// requester ports, with an owner-tag pipeline that routes each result back to its port.
module cmult_arbiter #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned TW_W     = 18,
   parameter int unsigned MULT_LAT = 3
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              hold_i,
   // port 0 request
   input  logic              s0_valid_i,
   output logic              s0_ready_o,
   input  logic [DATA_W-1:0] s0_a_i,
   input  logic [DATA_W-1:0] s0_b_i,
   input  logic [TW_W-1:0]   s0_c_i,
   input  logic [TW_W-1:0]   s0_d_i,
   // port 1 request
   input  logic              s1_valid_i,
   output logic              s1_ready_o,
   input  logic [DATA_W-1:0] s1_a_i,
   input  logic [DATA_W-1:0] s1_b_i,
   input  logic [TW_W-1:0]   s1_c_i,
   input  logic [TW_W-1:0]   s1_d_i,
   // shared multiplier
   output logic              m_valid_o,
   output logic [DATA_W-1:0] m_a_o,
   output logic [DATA_W-1:0] m_b_o,
   output logic [TW_W-1:0]   m_c_o,
   output logic [TW_W-1:0]   m_d_o,
   input  logic [DATA_W-1:0] m_real_i,
   input  logic [DATA_W-1:0] m_img_i,
   // port 0 result
   output logic              o0_valid_o,
   output logic [DATA_W-1:0] o0_real_o,
   output logic [DATA_W-1:0] o0_img_o,
   // port 1 result
   output logic              o1_valid_o,
   output logic [DATA_W-1:0] o1_real_o,
   output logic [DATA_W-1:0] o1_img_o,
   output logic              idle_o
);

   localparam int unsigned TAG_N = MULT_LAT + 1;

   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [TW_W-1:0]   c;
      logic [TW_W-1:0]   d;
   } opnd_t;

   opnd_t             s0_op;
   opnd_t             s1_op;
   logic              gnt_c;
   logic              gnt_port_c;

   logic              prio_q,     prio_d;
   logic              m_valid_q,  m_valid_d;
   opnd_t             m_op_q,     m_op_d;
   logic [TAG_N-1:0]  tag_vld_q,  tag_vld_d;
   logic [TAG_N-1:0]  tag_own_q,  tag_own_d;
   logic              o0_valid_q, o0_valid_d;
   logic [DATA_W-1:0] o0_real_q,  o0_real_d;
   logic [DATA_W-1:0] o0_img_q,   o0_img_d;
   logic              o1_valid_q, o1_valid_d;
   logic [DATA_W-1:0] o1_real_q,  o1_real_d;
   logic [DATA_W-1:0] o1_img_q,   o1_img_d;

   assign s0_op = '{a: s0_a_i, b: s0_b_i, c: s0_c_i, d: s0_d_i};
   assign s1_op = '{a: s1_a_i, b: s1_b_i, c: s1_c_i, d: s1_d_i};

   // Round-robin grant; reset and hold both suppress any grant this cycle.
   always_comb begin
      gnt_c      = 1'b0;
      gnt_port_c = 1'b0;
      if (!rst_i && !hold_i) begin
         if (s0_valid_i && s1_valid_i) begin
            gnt_c      = 1'b1;
            gnt_port_c = prio_q;
         end else if (s0_valid_i) begin
            gnt_c      = 1'b1;
            gnt_port_c = 1'b0;
         end else if (s1_valid_i) begin
            gnt_c      = 1'b1;
            gnt_port_c = 1'b1;
         end
      end
   end

   assign s0_ready_o = gnt_c & ~gnt_port_c;
   assign s1_ready_o = gnt_c &  gnt_port_c;

   // Operand stage, owner-tag shift and result demux.
   always_comb begin
      prio_d     = prio_q;
      m_valid_d  = gnt_c;
      m_op_d     = m_op_q;
      tag_vld_d  = {tag_vld_q[TAG_N-2:0], gnt_c};
      tag_own_d  = {tag_own_q[TAG_N-2:0], gnt_port_c};
      o0_valid_d = 1'b0;
      o0_real_d  = o0_real_q;
      o0_img_d   = o0_img_q;
      o1_valid_d = 1'b0;
      o1_real_d  = o1_real_q;
      o1_img_d   = o1_img_q;

      if (gnt_c) begin
         prio_d = ~gnt_port_c;
         m_op_d = gnt_port_c ? s1_op : s0_op;
      end

      // The last tag lines up with the multiplier output for that op.
      if (tag_vld_q[TAG_N-1]) begin
         if (tag_own_q[TAG_N-1]) begin
            o1_valid_d = 1'b1;
            o1_real_d  = m_real_i;
            o1_img_d   = m_img_i;
         end else begin
            o0_valid_d = 1'b1;
            o0_real_d  = m_real_i;
            o0_img_d   = m_img_i;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prio_q     <= 1'b0;
         m_valid_q  <= 1'b0;
         m_op_q     <= '0;
         tag_vld_q  <= '0;
         tag_own_q  <= '0;
         o0_valid_q <= 1'b0;
         o0_real_q  <= '0;
         o0_img_q   <= '0;
         o1_valid_q <= 1'b0;
         o1_real_q  <= '0;
         o1_img_q   <= '0;
      end else begin
         prio_q     <= prio_d;
         m_valid_q  <= m_valid_d;
         m_op_q     <= m_op_d;
         tag_vld_q  <= tag_vld_d;
         tag_own_q  <= tag_own_d;
         o0_valid_q <= o0_valid_d;
         o0_real_q  <= o0_real_d;
         o0_img_q   <= o0_img_d;
         o1_valid_q <= o1_valid_d;
         o1_real_q  <= o1_real_d;
         o1_img_q   <= o1_img_d;
      end
   end

   assign m_valid_o  = m_valid_q;
   assign m_a_o      = m_op_q.a;
   assign m_b_o      = m_op_q.b;
   assign m_c_o      = m_op_q.c;
   assign m_d_o      = m_op_q.d;
   assign o0_valid_o = o0_valid_q;
   assign o0_real_o  = o0_real_q;
   assign o0_img_o   = o0_img_q;
   assign o1_valid_o = o1_valid_q;
   assign o1_real_o  = o1_real_q;
   assign o1_img_o   = o1_img_q;
   assign idle_o     = ~|tag_vld_q & ~m_valid_q & ~gnt_c;

endmodule

// File: tb/tb_cmult_arbiter.sv
// tb_cmult_arbiter: directed and random stimulus against a queue-based reference model
// of the shared complex-multiplier arbiter, with a behavioural pipelined multiplier.
module tb_cmult_arbiter;
   localparam int unsigned DW  = 32;
   localparam int unsigned TW  = 18;
   localparam int unsigned LAT = 3;

   logic          clk = 1'b0;
   logic          rst, hold;
   logic          s0_valid, s0_ready, s1_valid, s1_ready;
   logic [DW-1:0] s0_a, s0_b, s1_a, s1_b;
   logic [TW-1:0] s0_c, s0_d, s1_c, s1_d;
   logic          m_valid;
   logic [DW-1:0] m_a, m_b;
   logic [TW-1:0] m_c, m_d;
   logic [DW-1:0] m_real, m_img;
   logic          o0_valid, o1_valid;
   logic [DW-1:0] o0_real, o0_img, o1_real, o1_img;
   logic          idle;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   always #5 clk = ~clk;

   cmult_arbiter #(.DATA_W(DW), .TW_W(TW), .MULT_LAT(LAT)) dut (
      .clk_i(clk), .rst_i(rst), .hold_i(hold),
      .s0_valid_i(s0_valid), .s0_ready_o(s0_ready),
      .s0_a_i(s0_a), .s0_b_i(s0_b), .s0_c_i(s0_c), .s0_d_i(s0_d),
      .s1_valid_i(s1_valid), .s1_ready_o(s1_ready),
      .s1_a_i(s1_a), .s1_b_i(s1_b), .s1_c_i(s1_c), .s1_d_i(s1_d),
      .m_valid_o(m_valid), .m_a_o(m_a), .m_b_o(m_b), .m_c_o(m_c), .m_d_o(m_d),
      .m_real_i(m_real), .m_img_i(m_img),
      .o0_valid_o(o0_valid), .o0_real_o(o0_real), .o0_img_o(o0_img),
      .o1_valid_o(o1_valid), .o1_real_o(o1_real), .o1_img_o(o1_img),
      .idle_o(idle)
   );

   function automatic logic [DW-1:0] cm_re(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [TW-1:0] c, input logic [TW-1:0] d);
      longint sa, sb, sc, sd;
      sa = longint'($signed(a)); sb = longint'($signed(b));
      sc = longint'($signed(c)); sd = longint'($signed(d));
      return DW'(sa * sc - sb * sd);
   endfunction

   function automatic logic [DW-1:0] cm_im(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [TW-1:0] c, input logic [TW-1:0] d);
      longint sa, sb, sc, sd;
      sa = longint'($signed(a)); sb = longint'($signed(b));
      sc = longint'($signed(c)); sd = longint'($signed(d));
      return DW'(sa * sd + sb * sc);
   endfunction

   // Behavioural multiplier: LAT register stages, computes every cycle.
   logic [DW-1:0] pre [LAT];
   logic [DW-1:0] pim [LAT];
   always @(posedge clk) begin
      pre[0] <= cm_re(m_a, m_b, m_c, m_d);
      pim[0] <= cm_im(m_a, m_b, m_c, m_d);
      for (int k = 1; k < LAT; k++) begin
         pre[k] <= pre[k-1];
         pim[k] <= pim[k-1];
      end
   end
   assign m_real = pre[LAT-1];
   assign m_img  = pim[LAT-1];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
      end
   endtask

   // Reference model: pending results carry the cycle in which they must appear.
   typedef struct {
      int            due;
      bit            port;
      logic [DW-1:0] re;
      logic [DW-1:0] im;
   } res_t;

   res_t          pend[$];
   bit            mdl_ok = 1'b0;
   bit            prio_m = 1'b0;
   bit            mv_m   = 1'b0;
   logic [DW-1:0] ma_m = '0, mb_m = '0;
   logic [TW-1:0] mc_m = '0, md_m = '0;
   bit            o0v_m = 1'b0, o1v_m = 1'b0;
   logic [DW-1:0] o0r_m = '0, o0i_m = '0, o1r_m = '0, o1i_m = '0;

   always @(negedge clk) begin
      bit   g, gp, busy;
      res_t r;
      g  = 1'b0;
      gp = 1'b0;
      if (!rst && !hold && (s0_valid || s1_valid)) begin
         g  = 1'b1;
         gp = (s0_valid && s1_valid) ? prio_m : s1_valid;
      end
      busy = 1'b0;
      foreach (pend[i]) if (pend[i].due > cyc) busy = 1'b1;

      if (mdl_ok) begin
         chk("s0_ready", 64'(s0_ready), 64'(g && !gp));
         chk("s1_ready", 64'(s1_ready), 64'(g && gp));
         chk("m_valid",  64'(m_valid),  64'(mv_m));
         chk("m_a",      64'(m_a),      64'(ma_m));
         chk("m_b",      64'(m_b),      64'(mb_m));
         chk("m_c",      64'(m_c),      64'(mc_m));
         chk("m_d",      64'(m_d),      64'(md_m));
         chk("o0_valid", 64'(o0_valid), 64'(o0v_m));
         chk("o0_real",  64'(o0_real),  64'(o0r_m));
         chk("o0_img",   64'(o0_img),   64'(o0i_m));
         chk("o1_valid", 64'(o1_valid), 64'(o1v_m));
         chk("o1_real",  64'(o1_real),  64'(o1r_m));
         chk("o1_img",   64'(o1_img),   64'(o1i_m));
         chk("idle",     64'(idle),     64'(!busy && !g));
      end

      if (rst) begin
         pend.delete();
         prio_m = 1'b0; mv_m = 1'b0;
         ma_m = '0; mb_m = '0; mc_m = '0; md_m = '0;
         o0v_m = 1'b0; o1v_m = 1'b0;
         o0r_m = '0; o0i_m = '0; o1r_m = '0; o1i_m = '0;
         mdl_ok = 1'b1;
      end else begin
         o0v_m = 1'b0;
         o1v_m = 1'b0;
         if (pend.size() > 0 && pend[0].due == cyc + 1) begin
            r = pend.pop_front();
            if (r.port) begin
               o1v_m = 1'b1; o1r_m = r.re; o1i_m = r.im;
            end else begin
               o0v_m = 1'b1; o0r_m = r.re; o0i_m = r.im;
            end
         end
         mv_m = g;
         if (g) begin
            if (gp) begin
               ma_m = s1_a; mb_m = s1_b; mc_m = s1_c; md_m = s1_d;
            end else begin
               ma_m = s0_a; mb_m = s0_b; mc_m = s0_c; md_m = s0_d;
            end
            pend.push_back('{due: cyc + int'(LAT) + 2, port: gp,
                             re: cm_re(ma_m, mb_m, mc_m, md_m),
                             im: cm_im(ma_m, mb_m, mc_m, md_m)});
            prio_m = !gp;
         end
      end
      cyc++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rnd_ops();
      s0_a = $urandom; s0_b = $urandom; s0_c = TW'($urandom); s0_d = TW'($urandom);
      s1_a = $urandom; s1_b = $urandom; s1_c = TW'($urandom); s1_d = TW'($urandom);
   endtask

   task automatic pulse_rst();
      tick(); rst = 1'b1;
      tick(); rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; hold = 1'b0; s0_valid = 1'b0; s1_valid = 1'b0;
      s0_a = '0; s0_b = '0; s0_c = '0; s0_d = '0;
      s1_a = '0; s1_b = '0; s1_c = '0; s1_d = '0;
      repeat (3) tick();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_m_valid",  64'(m_valid),  64'd0);
      chk("rst_o0_valid", 64'(o0_valid), 64'd0);
      chk("rst_idle",     64'(idle),     64'd1);
      chk("rst_m_a",      64'(m_a),      64'd0);

      // single op on port 0: (3+j)*(1-j) = 4-2j
      tick();
      s0_valid = 1'b1; s0_a = 32'd3; s0_b = 32'd1; s0_c = 18'd1; s0_d = TW'(-1);
      @(negedge clk);
      chk("t1_ready", 64'(s0_ready), 64'd1);
      tick();
      s0_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("t1_early", 64'(o0_valid), 64'd0);
      @(negedge clk);
      chk("t1_valid", 64'(o0_valid), 64'd1);
      chk("t1_real",  64'(o0_real),  64'd4);
      chk("t1_img",   64'(o0_img),   64'($unsigned(DW'(-2))));
      chk("t1_o1",    64'(o1_valid), 64'd0);

      // both ports valid for 8 cycles
      pulse_rst();
      for (int i = 0; i < 8; i++) begin
         rnd_ops();
         s0_valid = 1'b1; s1_valid = 1'b1;
         @(negedge clk);
         if (i == 0) chk("t2_first", 64'(s0_ready), 64'd1);
         if (i == 1) chk("t2_second", 64'(s1_ready), 64'd1);
         tick();
      end
      s0_valid = 1'b0; s1_valid = 1'b0;
      repeat (8) tick();

      // port 1 alone, a = 1..6
      for (int k = 0; k < 11; k++) begin
         s0_valid = 1'b0;
         if (k < 6) begin
            s1_valid = 1'b1; s1_a = DW'(k + 1); s1_b = '0; s1_c = 18'd1; s1_d = '0;
         end else begin
            s1_valid = 1'b0;
         end
         @(negedge clk);
         if (k < 6) chk("t3_ready", 64'(s1_ready), 64'd1);
         if (k >= 5) begin
            chk("t3_valid", 64'(o1_valid), 64'd1);
            chk("t3_real",  64'(o1_real),  64'(k - 4));
            chk("t3_img",   64'(o1_img),   64'd0);
         end
         tick();
      end

      // 4-op burst then hold with both valid
      pulse_rst();
      for (int i = 0; i < 4; i++) begin
         rnd_ops();
         s0_valid = 1'b1; s1_valid = 1'b1;
         @(negedge clk);
         tick();
      end
      hold = 1'b1;
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         if (j == 0) begin
            chk("t4_hold_r0", 64'(s0_ready), 64'd0);
            chk("t4_hold_r1", 64'(s1_ready), 64'd0);
         end
         if (j == 7) chk("t4_idle", 64'(idle), 64'd1);
         tick();
      end
      hold = 1'b0;
      @(negedge clk);
      chk("t4_resume", 64'(s0_ready), 64'd1);
      tick();
      s0_valid = 1'b0; s1_valid = 1'b0;
      repeat (8) tick();

      // reset in the middle of a burst
      for (int i = 0; i < 5; i++) begin
         rnd_ops();
         s0_valid = 1'b1; s1_valid = 1'b1;
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("t5_m_valid", 64'(m_valid),  64'd0);
      chk("t5_o0",      64'(o0_valid), 64'd0);
      chk("t5_o1",      64'(o1_valid), 64'd0);
      chk("t5_first",   64'(s0_ready), 64'd1);
      tick();
      s0_valid = 1'b0; s1_valid = 1'b0;
      repeat (8) tick();

      // no requests for 10 cycles
      for (int i = 0; i < 10; i++) begin
         rnd_ops();
         @(negedge clk);
         chk("t6_idle",    64'(idle),    64'd1);
         chk("t6_m_valid", 64'(m_valid), 64'd0);
         tick();
      end

      // random traffic with occasional hold and reset
      for (int i = 0; i < 400; i++) begin
         rnd_ops();
         s0_valid = ($urandom_range(0, 9) < 7);
         s1_valid = ($urandom_range(0, 9) < 6);
         hold     = ($urandom_range(0, 99) < 15);
         rst      = ($urandom_range(0, 99) < 2);
         tick();
      end
      rst = 1'b0; hold = 1'b0; s0_valid = 1'b0; s1_valid = 1'b0;
      repeat (10) tick();
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
